// File: rtl/wb_stage_if.sv
// Write-back stage bus bundle: EX-side handshake, register-file write port,
// forwarding tap and retire counter.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) ();
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_is_load;
    logic [DATA_W-1:0] ex_alu_res;
    logic [DATA_W-1:0] ex_ld_res;
    logic [1:0]        ex_ld_size;
    logic              ex_ld_signed;
    logic              ex_wen;
    logic [REG_AW-1:0] ex_rd;
    logic              wb_stall;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [15:0]       retire_cnt;

    // Pipeline/environment side: drives results and stall, observes the stage.
    modport master (
        output ex_valid, ex_is_load, ex_alu_res, ex_ld_res, ex_ld_size,
               ex_ld_signed, ex_wen, ex_rd, wb_stall,
        input  ex_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd,
               fwd_data, retire_cnt
    );

    // The write-back stage itself.
    modport slave (
        input  ex_valid, ex_is_load, ex_alu_res, ex_ld_res, ex_ld_size,
               ex_ld_signed, ex_wen, ex_rd, wb_stall,
        output ex_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd,
               fwd_data, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: 2-entry in-order result buffer feeding the register file,
// with load extension on entry, newest-match forwarding and a retire counter.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);
    // live = entry will actually write the register file (wen and rd != 0)
    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t      head_q, head_d, tail_q, tail_d, new_ent;
    logic        head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ready, accept, drain;

    function automatic logic [DATA_W-1:0] ext_load(input logic [DATA_W-1:0] raw,
                                                   input logic [1:0]        size,
                                                   input logic              sgn);
        logic              fill;
        logic [DATA_W-1:0] res;
        fill = 1'b0;
        res  = raw;
        case (size)
            2'b00: begin
                fill = sgn & raw[7];
                res  = {{(DATA_W-8){fill}}, raw[7:0]};
            end
            2'b01: begin
                fill = sgn & raw[15];
                res  = {{(DATA_W-16){fill}}, raw[15:0]};
            end
            default: res = raw;
        endcase
        return res;
    endfunction

    // Ready depends only on occupancy, so a full buffer never takes a result
    // even if the head drains in the same cycle.
    assign ready  = ~tail_vld_q;
    assign accept = bus.ex_valid & ready;
    assign drain  = head_vld_q & ~bus.wb_stall;

    // Format the incoming result as a buffer entry.
    always_comb begin
        new_ent      = '0;
        new_ent.live = bus.ex_wen & (bus.ex_rd != '0);
        new_ent.rd   = bus.ex_rd;
        new_ent.data = bus.ex_is_load ?
                       ext_load(bus.ex_ld_res, bus.ex_ld_size, bus.ex_ld_signed) :
                       bus.ex_alu_res;
    end

    // Buffer next state: drain shifts tail into head, then accept fills the
    // first free slot.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        cnt_d      = cnt_q;
        if (drain) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_d     = '0;
            tail_vld_d = 1'b0;
            cnt_d      = cnt_q + 16'd1;
        end
        if (accept) begin
            if (!head_vld_d) begin
                head_d     = new_ent;
                head_vld_d = 1'b1;
            end else begin
                tail_d     = new_ent;
                tail_vld_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset that discards any in-flight entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ex_ready   = ready;
    assign bus.rf_we      = drain & head_q.live;
    assign bus.rf_waddr   = head_vld_q ? head_q.rd   : '0;
    assign bus.rf_wdata   = head_vld_q ? head_q.data : '0;
    assign bus.retire_cnt = cnt_q;

    // Forwarding picks the newest live entry; tail is younger than head.
    always_comb begin
        bus.fwd_valid = 1'b0;
        bus.fwd_rd    = '0;
        bus.fwd_data  = '0;
        if (tail_vld_q && tail_q.live) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_rd    = tail_q.rd;
            bus.fwd_data  = tail_q.data;
        end else if (head_vld_q && head_q.live) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_rd    = head_q.rd;
            bus.fwd_data  = head_q.data;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed results, scoreboard of expected register
// writes popped by a monitor whenever rf_we is seen.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
    wb_stage #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   wr_cyc[$];
    int   pass_cnt = 0;
    int   total    = 0;
    int   cyc      = 0;
    int   exp_cnt  = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every register-file write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (mon_en && bus.rf_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: rf_we=%b waddr=%0d wdata=0x%08h, required no write",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.rf_waddr), 32'(e.rd));
                chk("wr_data", bus.rf_wdata, e.data);
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit is_load, input logic [31:0] alu, input logic [31:0] ld,
                        input logic [1:0] sz, input bit sgn, input bit wen,
                        input logic [4:0] rd, input logic [31:0] expv);
        int guard;
        exp_t e;
        bus.ex_valid     = 1'b1;
        bus.ex_is_load   = is_load;
        bus.ex_alu_res   = alu;
        bus.ex_ld_res    = ld;
        bus.ex_ld_size   = sz;
        bus.ex_ld_signed = sgn;
        bus.ex_wen       = wen;
        bus.ex_rd        = rd;
        guard = 0;
        while (bus.ex_ready !== 1'b1 && guard < 100) begin
            cycles(1);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            $display("FAIL accept_timeout: ex_ready=%b after 100 cycles, required 1", bus.ex_ready);
        end else begin
            if (wen && rd != 5'd0) begin
                e.rd   = rd;
                e.data = expv;
                exp_q.push_back(e);
            end
            exp_cnt++;
            cycles(1);
        end
        bus.ex_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] v);
        send(1'b0, v, 32'hA5A5A5A5, 2'b10, 1'b1, 1'b1, rd, v);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.ex_valid     = 1'b0;
        bus.ex_is_load   = 1'b0;
        bus.ex_alu_res   = '0;
        bus.ex_ld_res    = '0;
        bus.ex_ld_size   = '0;
        bus.ex_ld_signed = 1'b0;
        bus.ex_wen       = 1'b0;
        bus.ex_rd        = '0;
        bus.wb_stall     = 1'b0;
        cycles(3);
        chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
        chk("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        chk("rst_fwd_rd", 32'(bus.fwd_rd), 32'd0);
        chk("rst_fwd_data", bus.fwd_data, 32'd0);
        chk("rst_retire_cnt", 32'(bus.retire_cnt), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycles(1);

        // Load extension and single-cycle latency.
        send(1'b1, 32'h0, 32'h000000F0, 2'b00, 1'b1, 1'b1, 5'd3, 32'hFFFFFFF0);
        chk("latency_rf_we", 32'(bus.rf_we), 32'd1);
        send(1'b1, 32'h0, 32'h000000F0, 2'b00, 1'b0, 1'b1, 5'd3, 32'h000000F0);
        send(1'b1, 32'h0, 32'h00008001, 2'b01, 1'b1, 1'b1, 5'd10, 32'hFFFF8001);
        send(1'b1, 32'h0, 32'h12348001, 2'b01, 1'b0, 1'b1, 5'd11, 32'h00008001);
        send(1'b1, 32'h0, 32'hABCD127F, 2'b00, 1'b1, 1'b1, 5'd12, 32'h0000007F);
        send(1'b1, 32'h0, 32'h80000001, 2'b10, 1'b1, 1'b1, 5'd13, 32'h80000001);
        send(1'b1, 32'h0, 32'h80000001, 2'b11, 1'b0, 1'b1, 5'd14, 32'h80000001);
        send(1'b0, 32'h12345678, 32'hFFFFFFFF, 2'b00, 1'b1, 1'b1, 5'd31, 32'h12345678);
        cycles(2);
        chk("cnt_after_loads", 32'(bus.retire_cnt), 32'(16'(exp_cnt)));

        // Non-writing entries retire and count without rf_we.
        send(1'b0, 32'h0000DEAD, 32'h0, 2'b10, 1'b0, 1'b1, 5'd0, 32'h0000DEAD);
        send(1'b0, 32'h0000BEEF, 32'h0, 2'b10, 1'b0, 1'b0, 5'd7, 32'h0000BEEF);
        cycles(2);
        chk("cnt_after_nowrite", 32'(bus.retire_cnt), 32'(16'(exp_cnt)));

        // Full buffer under stall, third result held, then drained in order.
        bus.wb_stall = 1'b1;
        alu(5'd1, 32'h000000A1);
        alu(5'd2, 32'h000000A2);
        chk("full_ex_ready", 32'(bus.ex_ready), 32'd0);
        fork
            alu(5'd4, 32'h000000A4);
            begin
                cycles(3);
                chk("held_ex_ready", 32'(bus.ex_ready), 32'd0);
                chk("stall_rf_we", 32'(bus.rf_we), 32'd0);
                wr_cyc.delete();
                bus.wb_stall = 1'b0;
            end
        join
        cycles(3);
        chk("drain_nwrites", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() >= 3) begin
            chk("drain_consec1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
            chk("drain_consec2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
        end

        // Forwarding: tail wins on same rd.
        bus.wb_stall = 1'b1;
        alu(5'd5, 32'h00000011);
        chk("fwd1_valid", 32'(bus.fwd_valid), 32'd1);
        chk("fwd1_data", bus.fwd_data, 32'h00000011);
        alu(5'd5, 32'h00000022);
        chk("fwd2_rd", 32'(bus.fwd_rd), 32'd5);
        chk("fwd2_data", bus.fwd_data, 32'h00000022);
        bus.wb_stall = 1'b0;
        cycles(1);
        chk("fwd3_data", bus.fwd_data, 32'h00000022);
        cycles(2);
        chk("fwd_empty_valid", 32'(bus.fwd_valid), 32'd0);

        // Tail with rd 0 is not a forwarding candidate; head is used.
        bus.wb_stall = 1'b1;
        alu(5'd6, 32'h00000066);
        alu(5'd0, 32'h00000099);
        chk("fwd_skip_rd", 32'(bus.fwd_rd), 32'd6);
        chk("fwd_skip_data", bus.fwd_data, 32'h00000066);
        bus.wb_stall = 1'b0;
        cycles(3);

        // Mid-operation reset discards buffered entries.
        bus.wb_stall = 1'b1;
        alu(5'd8, 32'h00000088);
        alu(5'd9, 32'h00000099);
        chk("pre_rst_fwd_rd", 32'(bus.fwd_rd), 32'd9);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        bus.wb_stall = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        #1;
        chk("mrst_ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("mrst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("mrst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        chk("mrst_retire_cnt", 32'(bus.retire_cnt), 32'd0);
        cycles(3);

        // Retire counter wrap: 65535 streamed drains, then one more.
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b0;
        bus.ex_alu_res = 32'h0;
        bus.ex_wen     = 1'b1;
        bus.ex_rd      = 5'd0;
        cycles(65535);
        bus.ex_valid = 1'b0;
        exp_cnt = exp_cnt + 65535;
        cycles(1);
        chk("cnt_ffff", 32'(bus.retire_cnt), 32'h0000FFFF);
        alu(5'd0, 32'h00000001);
        cycles(2);
        chk("cnt_wrap", 32'(bus.retire_cnt), 32'(16'(exp_cnt)));

        cycles(2);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result data width.
REQ-002 SHALL have parameter REG_AW, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ex_valid  input  1  EX stage presents a result.
REQ-006 SHALL have port ex_ready  output  1  stage can accept a result this cycle.
REQ-007 SHALL have port ex_is_load  input  1  1 = write back load data, 0 = write back ALU result.
REQ-008 SHALL have port ex_alu_res  input  DATA_W  ALU result.
REQ-009 SHALL have port ex_ld_res  input  DATA_W  raw load data, right-aligned.
REQ-010 SHALL have port ex_ld_size  input  2  00 byte, 01 half, 10/11 word.
REQ-011 SHALL have port ex_ld_signed  input  1  1 = sign-extend load, 0 = zero-extend.
REQ-012 SHALL have port ex_wen  input  1  instruction writes a register.
REQ-013 SHALL have port ex_rd  input  REG_AW  destination register.
REQ-014 SHALL have port wb_stall  input  1  register-file write port busy this cycle.
REQ-015 SHALL have port rf_we  output  1  register-file write enable.
REQ-016 SHALL have port rf_waddr  output  REG_AW  write address.
REQ-017 SHALL have port rf_wdata  output  DATA_W  write data.
REQ-018 SHALL have port fwd_valid  output  1  forwarding entry valid.
REQ-019 SHALL have port fwd_rd  output  REG_AW  forwarding register index.
REQ-020 SHALL have port fwd_data  output  DATA_W  forwarding data.
REQ-021 SHALL have port retire_cnt  output  16  count of drained entries.

Function
REQ-022 SHALL hold results in a 2-entry in-order buffer (head = oldest, tail = newest).
REQ-023 SHALL drive ex_ready = 1 iff fewer than 2 entries are occupied, from current state only (no same-cycle bypass when full).
REQ-024 SHALL accept on rising edge when ex_valid & ex_ready; inputs ignored otherwise.
REQ-025 SHALL compute stored value on accept: ex_is_load ? ext(ex_ld_res) : ex_alu_res.
REQ-026 SHALL define ext(): byte uses bits [7:0], half bits [15:0], word all bits; upper bits filled with selected MSB if ex_ld_signed, else zeros.
REQ-027 SHALL drain head when head valid & ~wb_stall; drain and accept in the same cycle both take effect.
REQ-028 SHALL drive rf_we = head valid & ~wb_stall & head wen & (head rd != 0); rf_waddr/rf_wdata = head rd/value (0 when empty).
REQ-029 SHALL retire entries with wen = 0 or rd = 0 normally (drained, counted) without asserting rf_we.
REQ-030 SHALL set latency: result accepted at edge N into empty buffer appears on rf_* in cycle after N if wb_stall = 0.
REQ-031 SHALL drive fwd_valid/fwd_rd/fwd_data from the newest valid entry with wen = 1 and rd != 0; when both entries match the same rd, tail wins; fwd_valid = 0 if none.
REQ-032 SHALL increment retire_cnt by 1 per drain, wrapping 0xFFFF -> 0x0000.
REQ-033 SHALL keep buffer contents and order unchanged while wb_stall = 1.

Reset
REQ-034 SHALL on rising edge with rst_n = 0 empty both entries, clear retire_cnt to 0, regardless of pending accept/drain.
REQ-035 SHALL during and after reset until first accept drive ex_ready = 1, rf_we = 0, rf_waddr = 0, rf_wdata = 0, fwd_valid = 0, fwd_rd = 0, fwd_data = 0.
REQ-036 SHALL discard in-flight entries on mid-operation reset; no rf_we for them afterwards.

Verification
REQ-037 SHALL pass: load, size 00, signed, ld_res 0x000000F0, rd 3, wb_stall 0 -> next cycle rf_we 1, rf_waddr 3, rf_wdata 0xFFFFFFF0; same with signed 0 -> 0x000000F0.
REQ-038 SHALL pass: wb_stall 1, three back-to-back ALU results (rd 1,2,4) -> ex_ready 0 after two accepts, third held; release stall -> writes rd 1,2,4 in order on consecutive cycles.
REQ-039 SHALL pass: entries rd 5 value 0x11 then rd 5 value 0x22 under stall -> fwd_rd 5, fwd_data 0x22.
REQ-040 SHALL pass: ALU result rd 0 value 0xDEAD -> rf_we stays 0, retire_cnt increments by 1.
REQ-041 SHALL pass: retire_cnt preset by 65535 drains, one more drain -> retire_cnt 0.
REQ-042 SHALL pass: two entries buffered, rst_n 0 for one edge -> ex_ready 1, rf_we 0, fwd_valid 0, retire_cnt 0 on following cycle.
